// File: rtl/utpu_pkg.sv
// Shared uTPU definitions: datapath widths, opcode encoding and the packetizer
// state encoding, used by the packetizer and the decoding controller.
package utpu_pkg;

  localparam int BUFFER_WORD_SIZE = 16;
  localparam int FIFO_DATA_WIDTH  = 8;
  localparam int ADDRESS_SIZE     = 10;
  localparam int OPCODE_WIDTH     = 3;

  // A STORE only carries its address operand on the wire when this bit is set.
  localparam int STORE_ADDR_BIT   = 4;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_STORE = 3'd0,
    OP_FETCH = 3'd1,
    OP_RUN   = 3'd2,
    OP_LOAD  = 3'd3,
    OP_HALT  = 3'd4,
    OP_NOP   = 3'd5
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INSTR_LO = 3'd1,
    S_INSTR_HI = 3'd2,
    S_ADDR_LO  = 3'd3,
    S_ADDR_HI  = 3'd4,
    S_HALTED   = 3'd5
  } pkt_state_e;

  function automatic logic op_is_legal(input logic [OPCODE_WIDTH-1:0] op);
    return op <= OP_NOP;
  endfunction

endpackage

// File: rtl/instr_packetizer.sv
// Serializes accepted instruction words (plus the STORE address when flagged)
// into little-endian bytes for the TX FIFO, with HALT parking and illegal-op flagging.
module instr_packetizer
  import utpu_pkg::*;
#(
  parameter int BUFFER_WORD_SIZE = utpu_pkg::BUFFER_WORD_SIZE,
  parameter int FIFO_DATA_WIDTH  = utpu_pkg::FIFO_DATA_WIDTH,
  parameter int ADDRESS_SIZE     = utpu_pkg::ADDRESS_SIZE,
  parameter int OPCODE_WIDTH     = utpu_pkg::OPCODE_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BUFFER_WORD_SIZE-1:0] in_instr,
  input  logic [ADDRESS_SIZE-1:0]     in_addr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FIFO_DATA_WIDTH-1:0]  out_byte,
  input  logic                        halt_clr,
  output logic                        halted,
  output logic                        err,
  output logic [15:0]                 word_count,
  output logic [2:0]                  state_dbg
);

  // Handshakes: a transfer happens on a posedge where valid && ready are both
  // high; a valid source holds its data stable until that transfer.

  pkt_state_e                  state_q, state_d;
  logic [BUFFER_WORD_SIZE-1:0] instr_q;
  logic [ADDRESS_SIZE-1:0]     addr_q;
  logic                        err_q;
  logic [15:0]                 word_count_q;
  logic                        accept;
  logic                        accept_legal;
  logic                        word_done;
  opcode_e                     op_q;

  assign in_ready     = (state_q == S_IDLE) && !rst;
  assign accept       = in_valid && in_ready;
  assign accept_legal = op_is_legal(in_instr[OPCODE_WIDTH-1:0]);
  assign op_q         = opcode_e'(instr_q[OPCODE_WIDTH-1:0]);

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_byte  = '0;
    word_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && accept_legal) state_d = S_INSTR_LO;
      end
      S_INSTR_LO: begin
        out_valid = 1'b1;
        out_byte  = instr_q[FIFO_DATA_WIDTH-1:0];
        if (out_ready) state_d = S_INSTR_HI;
      end
      S_INSTR_HI: begin
        out_valid = 1'b1;
        out_byte  = instr_q[FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
        if (out_ready) begin
          if (op_q == OP_STORE && instr_q[STORE_ADDR_BIT]) begin
            state_d = S_ADDR_LO;
          end else begin
            word_done = 1'b1;
            state_d   = (op_q == OP_HALT) ? S_HALTED : S_IDLE;
          end
        end
      end
      S_ADDR_LO: begin
        out_valid = 1'b1;
        out_byte  = addr_q[FIFO_DATA_WIDTH-1:0];
        if (out_ready) state_d = S_ADDR_HI;
      end
      S_ADDR_HI: begin
        out_valid = 1'b1;
        out_byte  = FIFO_DATA_WIDTH'(addr_q[ADDRESS_SIZE-1:FIFO_DATA_WIDTH]);
        if (out_ready) begin
          word_done = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_HALTED: begin
        if (halt_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      instr_q      <= '0;
      addr_q       <= '0;
      err_q        <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && !accept_legal;
      if (accept) begin
        instr_q <= in_instr;
        addr_q  <= in_addr;
      end
      if (word_done) word_count_q <= word_count_q + 16'd1;
    end
  end

  assign halted     = (state_q == S_HALTED);
  assign err        = err_q;
  assign word_count = word_count_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_instr_packetizer.sv
// Bench for instr_packetizer: directed vector table, reset/halt sequences and
// randomized words checked against a byte-queue reference model.
module tb_instr_packetizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [9:0]  in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        halt_clr;
  logic        halted;
  logic        err;
  logic [15:0] word_count;
  logic [2:0]  state_dbg;

  int          total = 0;
  int          bad = 0;
  int          exp_count = 0;
  int          ready_mode = 0;   // 0: always ready, 1: stalled, 2: random
  logic        rnd_bit = 1'b1;
  logic        stall_prev = 1'b0;
  logic [7:0]  byte_prev = 8'h00;
  logic [7:0]  exp_q[$];

  instr_packetizer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_addr(in_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_byte(out_byte), .halt_clr(halt_clr),
    .halted(halted), .err(err), .word_count(word_count), .state_dbg(state_dbg)
  );

  // clock / reset / ready generation
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit <= 1'($urandom_range(0, 1));
  end

  assign out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : rnd_bit;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // scoreboard: every handshaken byte must match the head of exp_q
  always @(negedge clk) begin
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev && out_valid) check("byte_hold", {24'h0, out_byte}, {24'h0, byte_prev});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_byte: got %0h required none", out_byte);
        end else begin
          check("byte", {24'h0, out_byte}, {24'h0, exp_q.pop_front()});
        end
      end
      stall_prev <= out_valid && !out_ready;
      byte_prev  <= out_byte;
    end
  end

  // reference model: bytes a word must produce, from the opcode rules alone
  task automatic model_word(input logic [15:0] instr, input logic [9:0] addr,
                            output int n, output logic e, output logic h);
    int op;
    op = int'(instr[2:0]);
    n = 0;
    e = (op > 5);
    h = (op == 4);
    if (!e) begin
      exp_q.push_back(instr[7:0]);
      exp_q.push_back(instr[15:8]);
      n = 2;
      if (op == 0 && instr[4]) begin
        exp_q.push_back(addr[7:0]);
        exp_q.push_back({6'b0, addr[9:8]});
        n = 4;
      end
    end
  endtask

  // driver: offer one word and return on the cycle after it is accepted
  task automatic send(input logic [15:0] instr, input logic [9:0] addr);
    logic got;
    got = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_instr = instr;
    in_addr  = addr;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept required accept of %0h", instr);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(inout int lat);
    while (!(exp_q.size() == 0 && (in_ready || halted)) && lat < 300) begin
      @(negedge clk);
      #1;
      lat++;
    end
    if (lat >= 300) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got %0d pending bytes required 0", exp_q.size());
    end
  endtask

  task automatic do_halt();
    check("halted_set", {31'b0, halted}, 32'd1);
    check("halted_in_ready", {31'b0, in_ready}, 32'd0);
    repeat ($urandom_range(1, 3)) begin
      @(negedge clk);
      #1;
      check("halted_hold", {30'b0, halted, out_valid}, 32'd2);
    end
    @(posedge clk);
    #1;
    halt_clr = 1'b1;
    @(posedge clk);
    #1;
    halt_clr = 1'b0;
    @(negedge clk);
    #1;
    check("halt_release", {30'b0, halted, in_ready}, 32'd1);
  endtask

  // one word end to end; expected bytes must already be queued
  task automatic run_word(input logic [15:0] instr, input logic [9:0] addr, input int n,
                          input logic e, input logic h, input int stall, input logic chk_lat);
    int lat;
    send(instr, addr);
    @(negedge clk);
    #1;
    lat = 1;
    check("err_pulse", {31'b0, err}, {31'b0, e});
    check("first_valid", {31'b0, out_valid}, {31'b0, (n > 0)});
    if (stall > 0) begin
      check("stall_byte", {24'h0, out_byte}, {24'h0, instr[7:0]});
      repeat (stall - 1) begin
        @(negedge clk);
        #1;
        check("stall_byte", {23'h0, out_valid, out_byte}, {23'h0, 1'b1, instr[7:0]});
      end
      @(posedge clk);
      #1;
      ready_mode = 0;
    end
    if (e) begin
      @(negedge clk);
      #1;
      lat++;
      check("err_one_cycle", {30'b0, err, out_valid}, 32'd0);
    end
    wait_done(lat);
    if (chk_lat && stall == 0 && !e) check("latency", lat, n + 1);
    if (!e) exp_count++;
    check("word_count", {16'h0, word_count}, 32'(exp_count & 16'hFFFF));
    if (h) do_halt();
    else check("not_halted", {31'b0, halted}, 32'd0);
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [9:0]  addr;
    int          stall;
    int          nbytes;
    logic [31:0] bytes;   // byte k at bits [8k+7:8k]
    logic        err_exp;
    logic        halt_exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int   n;
    logic e, h;
    logic [15:0] ri;
    logic [9:0]  ra;

    vecs[0]  = '{16'h1232, 10'h000, 0, 2, 32'h0000_1232, 1'b0, 1'b0};
    vecs[1]  = '{16'h0010, 10'h2A5, 0, 4, 32'h02A5_0010, 1'b0, 1'b0};
    vecs[2]  = '{16'h0000, 10'h3FF, 0, 2, 32'h0000_0000, 1'b0, 1'b0};
    vecs[3]  = '{16'hBEEA, 10'h000, 5, 2, 32'h0000_BEEA, 1'b0, 1'b0};
    vecs[4]  = '{16'h0004, 10'h000, 0, 2, 32'h0000_0004, 1'b0, 1'b1};
    vecs[5]  = '{16'h0006, 10'h155, 0, 0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[6]  = '{16'h0007, 10'h000, 0, 0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7]  = '{16'h0018, 10'h100, 0, 4, 32'h0100_0018, 1'b0, 1'b0};
    vecs[8]  = '{16'h00E8, 10'h3FF, 0, 2, 32'h0000_00E8, 1'b0, 1'b0};
    vecs[9]  = '{16'hFFFD, 10'h000, 0, 2, 32'h0000_FFFD, 1'b0, 1'b0};
    vecs[10] = '{16'h0011, 10'h2FF, 0, 2, 32'h0000_0011, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = 16'h0;
    in_addr = 10'h0;
    halt_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_outputs", {13'h0, out_valid, err, halted, out_byte, word_count}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < vecs[i].nbytes; k++) exp_q.push_back(vecs[i].bytes[8*k +: 8]);
      ready_mode = (vecs[i].stall > 0) ? 1 : 0;
      run_word(vecs[i].instr, vecs[i].addr, vecs[i].nbytes, vecs[i].err_exp,
               vecs[i].halt_exp, vecs[i].stall, 1'b1);
    end

    // reset after the first byte of a STORE: remaining bytes are dropped
    ready_mode = 0;
    exp_q.push_back(8'h10);
    send(16'h0010, 10'h123);
    @(negedge clk);
    #1;
    check("mid_first_byte", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_state", {15'h0, out_valid, word_count}, 32'd0);
    exp_count = 0;
    model_word(16'h0010, 10'h123, n, e, h);
    run_word(16'h0010, 10'h123, n, e, h, 0, 1'b1);

    // randomized words against the model with random backpressure
    ready_mode = 2;
    for (int i = 0; i < 250; i++) begin
      ri = 16'($urandom_range(0, 65535));
      ra = 10'($urandom_range(0, 1023));
      model_word(ri, ra, n, e, h);
      run_word(ri, ra, n, e, h, 0, 1'b0);
    end
    ready_mode = 0;

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
